// File: rtl/sspis_top.sv
// SPI mode-0 slave (MSB first) that turns serial frames into register bus transactions.
// sck/ssn/si are oversampled on clk; there is no sck clock domain.
module sspis_top #(
    parameter int DUMMY_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sck,
    input  logic        ssn,
    input  logic        si,
    output logic        so,
    output logic        so_en,
    output logic        reg_cs,
    output logic        reg_wr,
    output logic [31:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic [3:0]  reg_be,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack
);

    // state    | meaning
    // IDLE     | wait for ssn falling edge
    // CMD      | shift in 8-bit command (opcode, byte enables)
    // ADDR     | shift in 32-bit address; read request issued at the end
    // WDATA    | shift in 32-bit write data; write request issued at the end
    // BUSWR    | wait for the write acknowledge
    // DUMMY    | turnaround cycles while the bus read completes
    // RDATA    | shift read data out on sck falling edges
    // IGNORE   | frame done or unsupported opcode; wait for ssn high
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_BUSWR, S_DUMMY, S_RDATA, S_IGNORE
    } state_t;

    localparam logic [3:0] OP_WR    = 4'h1;
    localparam logic [3:0] OP_RD    = 4'h2;
    localparam logic [5:0] DUMMY_TC = 6'(DUMMY_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sck_s1, r_sck_s2, r_sck_d;
    logic        r_ssn_s1, r_ssn_s2, r_ssn_d;
    logic        r_si_s1, r_si_s2;

    logic [5:0]  r_cnt;
    logic [31:0] r_shift;
    logic        r_is_rd;
    logic [3:0]  r_be_sh;
    logic [31:0] r_addr_sh;
    logic [31:0] r_wdata_sh;
    logic        r_wait;
    logic        r_wait_wr;
    logic [31:0] r_rbuf;
    logic        r_rbuf_vld;
    logic        r_stale;

    logic        w_sck_rise, w_sck_fall, w_ssn_fall, w_ssn_hi;
    logic [31:0] w_shift_nxt;
    logic [31:0] w_rd_word;
    logic        w_trig_rd, w_trig_wr, w_trig;
    logic        w_cmd_done, w_addr_done, w_load_tx;
    logic        w_shift_in, w_shift_out, w_cnt_inc;
    logic        w_rd_ack, w_capture, w_orphan, w_wr_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_d  <= 1'b0;
            r_ssn_s1 <= 1'b1;
            r_ssn_s2 <= 1'b1;
            r_ssn_d  <= 1'b1;
            r_si_s1  <= 1'b0;
            r_si_s2  <= 1'b0;
        end else begin
            r_sck_s1 <= sck;
            r_sck_s2 <= r_sck_s1;
            r_sck_d  <= r_sck_s2;
            r_ssn_s1 <= ssn;
            r_ssn_s2 <= r_ssn_s1;
            r_ssn_d  <= r_ssn_s2;
            r_si_s1  <= si;
            r_si_s2  <= r_si_s1;
        end
    end

    assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
    assign w_ssn_fall  = ~r_ssn_s2 & r_ssn_d;
    assign w_ssn_hi    = r_ssn_s2;
    assign so_en       = ~r_ssn_s2;
    assign w_shift_nxt = {r_shift[30:0], r_si_s2};

    assign w_trig    = w_trig_rd | w_trig_wr;
    assign w_rd_ack  = reg_cs & reg_ack & ~reg_wr;
    // A read ack seen after an earlier read timed out belongs to that stale read, not this frame
    assign w_capture = (r_state == S_DUMMY) & w_rd_ack & ~r_stale;
    assign w_orphan  = (r_state == S_DUMMY) & (w_state_nxt != S_DUMMY) & ~r_rbuf_vld & ~w_capture;
    assign w_wr_done = reg_cs & reg_ack & reg_wr & ~r_wait;
    assign w_rd_word = w_capture ? reg_rdata : (r_rbuf_vld ? r_rbuf : 32'h0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_ssn_fall) w_state_nxt = S_CMD;
            S_CMD: begin
                if (w_ssn_hi) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cmd_done) begin
                    if (w_shift_nxt[7:4] == OP_WR || w_shift_nxt[7:4] == OP_RD) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_state_nxt = S_IGNORE;
                    end
                end
            end
            S_ADDR: begin
                if (w_ssn_hi) w_state_nxt = S_IDLE;
                else if (w_addr_done) w_state_nxt = r_is_rd ? S_DUMMY : S_WDATA;
            end
            S_WDATA: begin
                if (w_ssn_hi) w_state_nxt = S_IDLE;
                else if (w_trig_wr) w_state_nxt = S_BUSWR;
            end
            S_BUSWR: begin
                // Leaving on ssn high keeps the request pending so the next frame can start
                if (w_wr_done) w_state_nxt = w_ssn_hi ? S_IDLE : S_IGNORE;
                else if (w_ssn_hi) w_state_nxt = S_IDLE;
            end
            S_DUMMY: begin
                if (w_ssn_hi) w_state_nxt = S_IDLE;
                else if (w_load_tx) w_state_nxt = S_RDATA;
            end
            S_RDATA: begin
                if (w_ssn_hi) w_state_nxt = S_IDLE;
                else if (w_sck_fall && r_cnt == 6'd31) w_state_nxt = S_IGNORE;
            end
            S_IGNORE: if (w_ssn_hi) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        so          = 1'b0;
        w_trig_rd   = 1'b0;
        w_trig_wr   = 1'b0;
        w_cmd_done  = 1'b0;
        w_addr_done = 1'b0;
        w_load_tx   = 1'b0;
        w_shift_in  = 1'b0;
        w_shift_out = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            S_CMD: begin
                if (!w_ssn_hi && w_sck_rise) begin
                    w_shift_in = 1'b1;
                    w_cnt_inc  = 1'b1;
                    w_cmd_done = (r_cnt == 6'd7);
                end
            end
            S_ADDR: begin
                if (!w_ssn_hi && w_sck_rise) begin
                    w_shift_in  = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_addr_done = (r_cnt == 6'd31);
                    w_trig_rd   = (r_cnt == 6'd31) && r_is_rd;
                end
            end
            S_WDATA: begin
                if (!w_ssn_hi && w_sck_rise) begin
                    w_shift_in = 1'b1;
                    w_cnt_inc  = 1'b1;
                    w_trig_wr  = (r_cnt == 6'd31);
                end
            end
            S_DUMMY: begin
                if (!w_ssn_hi) begin
                    w_cnt_inc = w_sck_rise && (r_cnt != DUMMY_TC);
                    w_load_tx = w_sck_fall && (r_cnt == DUMMY_TC);
                end
            end
            S_RDATA: begin
                so = r_shift[31];
                if (!w_ssn_hi && w_sck_fall) begin
                    w_shift_out = 1'b1;
                    w_cnt_inc   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 6'd0;
            r_shift    <= 32'h0;
            r_is_rd    <= 1'b0;
            r_be_sh    <= 4'h0;
            r_addr_sh  <= 32'h0;
            r_wdata_sh <= 32'h0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= 6'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 6'd1;
            end

            if (w_load_tx) begin
                r_shift <= w_rd_word;
            end else if (w_shift_in) begin
                r_shift <= w_shift_nxt;
            end else if (w_shift_out) begin
                r_shift <= {r_shift[30:0], 1'b0};
            end

            if (w_cmd_done) begin
                r_is_rd <= (w_shift_nxt[7:4] == OP_RD);
                r_be_sh <= w_shift_nxt[3:0];
            end
            if (w_addr_done) r_addr_sh  <= w_shift_nxt;
            if (w_trig_wr)   r_wdata_sh <= w_shift_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 32'h0;
            reg_wdata <= 32'h0;
            reg_be    <= 4'h0;
            r_wait    <= 1'b0;
            r_wait_wr <= 1'b0;
        end else begin
            if (reg_cs && reg_ack) reg_cs <= 1'b0;
            if (w_trig && !reg_cs) begin
                reg_cs   <= 1'b1;
                reg_wr   <= w_trig_wr;
                reg_be   <= r_be_sh;
                reg_addr <= w_trig_rd ? w_shift_nxt : r_addr_sh;
                if (w_trig_wr) reg_wdata <= w_shift_nxt;
            end else if (w_trig) begin
                r_wait    <= 1'b1;
                r_wait_wr <= w_trig_wr;
            end else if (r_wait && !reg_cs) begin
                reg_cs   <= 1'b1;
                reg_wr   <= r_wait_wr;
                reg_be   <= r_be_sh;
                reg_addr <= r_addr_sh;
                if (r_wait_wr) reg_wdata <= r_wdata_sh;
                r_wait   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rbuf     <= 32'h0;
            r_rbuf_vld <= 1'b0;
            r_stale    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_ssn_fall) r_rbuf_vld <= 1'b0;
            if (w_capture) begin
                r_rbuf     <= reg_rdata;
                r_rbuf_vld <= 1'b1;
            end
            if (w_rd_ack) r_stale <= 1'b0;
            if (w_orphan) r_stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sspis_top.sv
// Directed bench for sspis_top: bit-banged SPI master at sck=clk/8 plus a
// register-bus responder with a programmable acknowledge delay.
module tb_sspis_top;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sck, ssn, si;
    logic        so, so_en;
    logic        reg_cs, reg_wr;
    logic [31:0] reg_addr, reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    int          checks = 0;
    int          failures = 0;

    int          ack_delay = 3;
    logic [31:0] rd_data = 32'h0;
    int          cs_cnt = 0;
    int          req_count = 0;
    int          last_ack_cnt = 0;
    int          stab_err = 0;
    int          so_bad = 0;
    int          req0;
    logic        cap_wr;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic [31:0] rd;

    sspis_top #(.DUMMY_CYCLES(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sck       (sck),
        .ssn       (ssn),
        .si        (si),
        .so        (so),
        .so_en     (so_en),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    always #5 clk = ~clk;

    // Bus responder: logs each request and checks request fields stay stable until ack
    always @(posedge clk) begin
        #1;
        reg_ack = 1'b0;
        if (reg_cs) begin
            if (cs_cnt == 0) begin
                req_count++;
                cap_wr    = reg_wr;
                cap_addr  = reg_addr;
                cap_wdata = reg_wdata;
                cap_be    = reg_be;
            end else if (reg_wr !== cap_wr || reg_addr !== cap_addr ||
                         reg_wdata !== cap_wdata || reg_be !== cap_be) begin
                stab_err++;
            end
            cs_cnt++;
            if (cs_cnt == ack_delay) begin
                reg_ack      = 1'b1;
                reg_rdata    = rd_data;
                last_ack_cnt = cs_cnt;
            end
        end else begin
            cs_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        si = b;
        clk_wait(4);
        s = so;
        sck = 1'b1;
        clk_wait(4);
        sck = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] addr, input int addr_bits,
                             input logic [31:0] wdata, input int wdata_bits, input int dummy_bits,
                             input int rd_bits, input bit end_frame, output logic [31:0] rdw);
        logic s;
        ssn = 1'b0;
        clk_wait(8);
        for (int i = 0; i < 8; i++) begin
            bit_cycle(cmd[7-i], s);
            if (s !== 1'b0) so_bad++;
        end
        for (int i = 0; i < addr_bits; i++) begin
            bit_cycle(addr[31-i], s);
            if (s !== 1'b0) so_bad++;
        end
        for (int i = 0; i < wdata_bits; i++) begin
            bit_cycle(wdata[31-i], s);
            if (s !== 1'b0) so_bad++;
        end
        for (int i = 0; i < dummy_bits; i++) begin
            bit_cycle(1'b0, s);
            if (s !== 1'b0) so_bad++;
        end
        rdw = 32'h0;
        for (int i = 0; i < rd_bits; i++) begin
            bit_cycle(1'b0, s);
            rdw = {rdw[30:0], s};
        end
        if (end_frame) begin
            clk_wait(4);
            ssn = 1'b1;
            clk_wait(8);
            if (so !== 1'b0) so_bad++;
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        sck       = 1'b0;
        ssn       = 1'b1;
        si        = 1'b0;
        reg_ack   = 1'b0;
        reg_rdata = 32'h0;
        clk_wait(4);
        reset_n = 1'b1;
        clk_wait(4);

        chk("rst_cs",    {31'h0, reg_cs}, 32'h0);
        chk("rst_wr",    {31'h0, reg_wr}, 32'h0);
        chk("rst_addr",  reg_addr, 32'h0);
        chk("rst_wdata", reg_wdata, 32'h0);
        chk("rst_be",    {28'h0, reg_be}, 32'h0);
        chk("rst_so",    {31'h0, so}, 32'h0);
        chk("rst_so_en", {31'h0, so_en}, 32'h0);

        // write 0x1F / 0x104 / 0xA5A51234
        ack_delay = 3;
        so_bad = 0;
        req0 = req_count;
        spi_frame(8'h1F, 32'h0000_0104, 32, 32'hA5A5_1234, 32, 0, 0, 1'b1, rd);
        chk("wr1_reqs",  32'(req_count - req0), 32'd1);
        chk("wr1_wr",    {31'h0, cap_wr}, 32'h1);
        chk("wr1_addr",  cap_addr, 32'h0000_0104);
        chk("wr1_wdata", cap_wdata, 32'hA5A5_1234);
        chk("wr1_be",    {28'h0, cap_be}, 32'hF);
        chk("wr1_cs_done", {31'h0, reg_cs}, 32'h0);
        chk("wr1_so_zero", 32'(so_bad), 32'd0);

        // read 0x23 / 0x40, ack after 5 clk
        ack_delay = 5;
        rd_data = 32'hCAFE_F00D;
        so_bad = 0;
        req0 = req_count;
        spi_frame(8'h23, 32'h0000_0040, 32, 32'h0, 0, 8, 32, 1'b1, rd);
        chk("rd1_data", rd, 32'hCAFE_F00D);
        chk("rd1_reqs", 32'(req_count - req0), 32'd1);
        chk("rd1_wr",   {31'h0, cap_wr}, 32'h0);
        chk("rd1_addr", cap_addr, 32'h0000_0040);
        chk("rd1_be",   {28'h0, cap_be}, 32'h3);
        chk("rd1_so_zero", 32'(so_bad), 32'd0);

        // read with ack well past the dummy window: MISO returns zeros, late data discarded
        ack_delay = 120;
        rd_data = 32'h1234_5678;
        req0 = req_count;
        spi_frame(8'h2F, 32'h0000_0080, 32, 32'h0, 0, 8, 32, 1'b1, rd);
        chk("late_data",   rd, 32'h0);
        chk("late_held",   32'(last_ack_cnt), 32'd120);
        chk("late_reqs",   32'(req_count - req0), 32'd1);
        chk("late_cs_done", {31'h0, reg_cs}, 32'h0);

        ack_delay = 4;
        rd_data = 32'h0BAD_BEEF;
        spi_frame(8'h2F, 32'h0000_0084, 32, 32'h0, 0, 8, 32, 1'b1, rd);
        chk("after_late_data", rd, 32'h0BAD_BEEF);
        chk("after_late_addr", cap_addr, 32'h0000_0084);

        // unsupported opcode 0x7, then a valid write
        so_bad = 0;
        req0 = req_count;
        spi_frame(8'h7F, 32'h0000_0200, 32, 32'hFFFF_FFFF, 32, 0, 0, 1'b1, rd);
        chk("bad_op_reqs", 32'(req_count - req0), 32'd0);
        chk("bad_op_so",   32'(so_bad), 32'd0);

        ack_delay = 2;
        req0 = req_count;
        spi_frame(8'h13, 32'h0000_0300, 32, 32'h0000_5A5A, 32, 0, 0, 1'b1, rd);
        chk("wr2_reqs",  32'(req_count - req0), 32'd1);
        chk("wr2_wr",    {31'h0, cap_wr}, 32'h1);
        chk("wr2_addr",  cap_addr, 32'h0000_0300);
        chk("wr2_wdata", cap_wdata, 32'h0000_5A5A);
        chk("wr2_be",    {28'h0, cap_be}, 32'h3);

        // abort after 20 address bits, then a full read
        req0 = req_count;
        spi_frame(8'h2F, 32'hFFFF_F000, 20, 32'h0, 0, 0, 0, 1'b1, rd);
        clk_wait(16);
        chk("abort_reqs",  32'(req_count - req0), 32'd0);
        chk("abort_cs",    {31'h0, reg_cs}, 32'h0);
        chk("abort_so_en", {31'h0, so_en}, 32'h0);

        ack_delay = 2;
        rd_data = 32'h1357_9BDF;
        spi_frame(8'h2F, 32'h0000_0044, 32, 32'h0, 0, 8, 32, 1'b1, rd);
        chk("rd2_data", rd, 32'h1357_9BDF);
        chk("rd2_addr", cap_addr, 32'h0000_0044);

        // reset while a write is outstanding in BUSWR
        ack_delay = 1000000;
        spi_frame(8'h1F, 32'h0000_0500, 32, 32'hDEAD_BEEF, 32, 0, 0, 1'b0, rd);
        clk_wait(4);
        chk("busy_cs", {31'h0, reg_cs}, 32'h1);
        chk("busy_wr", {31'h0, reg_wr}, 32'h1);
        reset_n = 1'b0;
        ssn = 1'b1;
        #1;
        chk("arst_cs",    {31'h0, reg_cs}, 32'h0);
        chk("arst_wr",    {31'h0, reg_wr}, 32'h0);
        chk("arst_addr",  reg_addr, 32'h0);
        chk("arst_wdata", reg_wdata, 32'h0);
        chk("arst_be",    {28'h0, reg_be}, 32'h0);
        chk("arst_so_en", {31'h0, so_en}, 32'h0);
        clk_wait(3);
        reset_n = 1'b1;
        clk_wait(6);

        ack_delay = 2;
        req0 = req_count;
        spi_frame(8'h1C, 32'h0000_0600, 32, 32'h0F0F_0F0F, 32, 0, 0, 1'b1, rd);
        chk("wr3_reqs",  32'(req_count - req0), 32'd1);
        chk("wr3_addr",  cap_addr, 32'h0000_0600);
        chk("wr3_wdata", cap_wdata, 32'h0F0F_0F0F);
        chk("wr3_be",    {28'h0, cap_be}, 32'hC);
        chk("wr3_cs_done", {31'h0, reg_cs}, 32'h0);

        chk("req_stable", 32'(stab_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sspis_top.md
Name: sspis_top

Overview:
- SPI slave (mode 0, MSB first) that turns serial frames from an external SPI master into transactions on the peripheral register bus (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be, reg_rdata/reg_ack). It is the slave counterpart of the sspim master in the UART/I2C/USB/SPI peripheral cluster.
- It lets an external host read and write any register the bus reaches.
- sck, ssn and si are oversampled in the app clock domain; there is no sck clock domain.

Parameters:
- DUMMY_CYCLES, 8, number of sck cycles between the last address bit and the first read-data bit; bus read must ack within this window.

Ports:
- clk  input  1  app clock; all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- sck  input  1  SPI clock from external master
- ssn  input  1  SPI chip select, active low
- si  input  1  serial data in (MOSI)
- so  output  1  serial data out (MISO)
- so_en  output  1  MISO pad drive enable, active high
- reg_cs  output  1  bus request, held until reg_ack
- reg_wr  output  1  1=write, 0=read
- reg_addr  output  32  bus address
- reg_wdata  output  32  write data
- reg_be  output  4  byte enables
- reg_rdata  input  32  read data, valid with reg_ack
- reg_ack  input  1  one-cycle bus acknowledge

Behaviour:
- Reset: so=0, so_en=0, reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0, reg_be=0, FSM=IDLE, bit counter=0.
- Sync: sck, ssn and si each pass through 2-flop synchronizers.
- Edges: sck rise/fall are detected from the synced value vs a 1-cycle-delayed copy, giving 3 clk latency pin-to-event. sck high and low phases must each be ≥4 clk.
- so_en = synced ssn low. The shift register samples si on the sck rise event and updates so on the sck fall event.
- Frame layout:
  - 8-bit cmd: cmd[7:4] is the opcode (4'h1 write, 4'h2 read); cmd[3:0] is be.
  - 32-bit address.
  - Write: 32-bit wdata.
  - Read: DUMMY_CYCLES dummy cycles, then 32-bit rdata out.
- States:
  - IDLE: wait for synced ssn falling; clear bit counter; go to CMD.
  - CMD: after 8 rise events, latch be and opcode. Write/read opcode -> ADDR. Any other opcode -> IGNORE.
  - ADDR: after 32 rises, latch reg_addr. Write -> WDATA. Read -> assert reg_cs=1, reg_wr=0 in the same cycle, then go to DUMMY.
  - WDATA: after 32 rises, latch reg_wdata, assert reg_cs=1, reg_wr=1; go to BUSWR.
  - BUSWR: hold reg_cs until reg_ack; then deassert the next cycle and go to IGNORE (or IDLE if ssn already high).
  - DUMMY: count DUMMY_CYCLES rises. reg_ack during DUMMY captures reg_rdata into the read buffer and drops reg_cs.
    - On the fall event after the last dummy rise, load the shift register with the read buffer and drive bit 31; go to RDATA.
    - If no ack has arrived by then, load 32'h0, keep reg_cs asserted until ack (ack data discarded), and go to RDATA.
  - RDATA: shift one bit per fall event; after 32 bits go to IGNORE.
  - IGNORE: so=0; wait for synced ssn high -> IDLE.
- so is 0 in all states except RDATA.
- ssn high mid-frame in CMD/ADDR/WDATA/DUMMY/RDATA: the frame aborts to IDLE within 1 clk of the synced edge. No bus cycle is issued if the abort occurs before the trigger point.
- An outstanding reg_cs is never withdrawn before reg_ack. The FSM tracks this with a pending flag and does not issue a new request until it is cleared.
- Back-to-back frames: a new frame in IDLE is accepted while a previous write is pending. Its bus request is delayed until the pending ack.
- reg_addr, reg_wdata and reg_be are stable while reg_cs=1.
- Async reset mid-transaction: everything returns to reset values immediately, including reg_cs=0.
- The bit counter is 6-bit and clears on every state entry. No wrap is possible because each state exits at its terminal count.

Test Plan:
- Write frame 0x1F, 0x0000_0104, 0xA5A5_1234 at sck=clk/8 -> one reg_cs pulse-to-ack with reg_wr=1, addr=0x104, wdata=0xA5A51234, be=4'hF; exactly one request.
- Read frame 0x23, addr 0x40, bus acks after 5 clk with rdata=0xCAFE_F00D -> reg_wr=0, be=4'h3; MISO returns 0xCAFEF00D MSB first after 8 dummy cycles; so=0 outside RDATA.
- Read with ack delayed beyond the dummy window -> so shifts 0x00000000; reg_cs held until the late ack, then 0; next frame works normally.
- Opcode 0x7 frame -> no reg_cs, so stays 0; next valid write frame is executed correctly.
- ssn deasserted after 20 address bits -> no bus request, FSM in IDLE; a following complete read frame returns correct data.
- reset_n low while reg_cs=1 in BUSWR -> all outputs 0 immediately; after release, a write frame completes normally.
